// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller: state encoding,
// instruction field constants and datapath select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpAddi  = 6'h08;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [1:0] SrcBReg = 2'd0;
    localparam logic [1:0] SrcBOne = 2'd1;
    localparam logic [1:0] SrcBImm = 2'd2;

    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OpLw) || (op == OpSw);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type func field decoder: selects the ALU operation and flags unsupported
// func codes so DECODE can treat them as illegal.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] func_i,
    output logic [2:0] alu_sel_o,
    output logic       func_legal_o
);

    always_comb begin
        alu_sel_o    = AluAdd;
        func_legal_o = 1'b1;
        case (func_i)
            FnAdd:   alu_sel_o = AluAdd;
            FnSub:   alu_sel_o = AluSub;
            FnAnd:   alu_sel_o = AluAnd;
            FnOr:    alu_sel_o = AluOr;
            FnSlt:   alu_sel_o = AluSlt;
            default: func_legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle MIPS main controller (Moore FSM). Define CTRL_BNE_EN to accept
// bne (opcode 0x05), which shares the BRANCH state with inverted zero polarity.
module control_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUSel,
    output logic [3:0] state,
    output logic       illegal
);

    state_e     state_q, state_d;
    logic [2:0] func_sel;
    logic       func_legal;
    logic       op_legal;
    logic       pc_write;
    logic       branch;
    logic       branch_taken;

    alu_decoder u_alu_decoder (
        .func_i       (func),
        .alu_sel_o    (func_sel),
        .func_legal_o (func_legal)
    );

    always_comb begin
        case (opcode)
            OpRtype:                      op_legal = func_legal;
            OpLw, OpSw, OpBeq, OpJ, OpAddi: op_legal = 1'b1;
`ifdef CTRL_BNE_EN
            OpBne:                        op_legal = 1'b1;
`endif
            default:                      op_legal = 1'b0;
        endcase
    end

`ifdef CTRL_BNE_EN
    // Branch polarity is latched in DECODE so BRANCH needs no opcode compare.
    logic bne_q, bne_d;

    assign bne_d = (state_q == StDecode) ? (opcode == OpBne) : bne_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bne_q <= 1'b0;
        end else begin
            bne_q <= bne_d;
        end
    end

    assign branch_taken = zero ^ bne_q;
`else
    assign branch_taken = zero;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (!op_legal) begin
                    state_d = StFetch;
                end else if (is_mem_op(opcode)) begin
                    state_d = StMemAdr;
                end else begin
                    case (opcode)
                        OpRtype: state_d = StExec;
                        OpBeq:   state_d = StBranch;
`ifdef CTRL_BNE_EN
                        OpBne:   state_d = StBranch;
`endif
                        OpJ:     state_d = StJump;
                        OpAddi:  state_d = StAddiEx;
                        default: state_d = StFetch;
                    endcase
                end
            end
            StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  state_d = StFetch;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            StAddiEx: state_d = StAddiWb;
            StAddiWb: state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    // Asynchronous reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SrcBReg;
        PCSource = PcSrcAlu;
        ALUSel   = AluAnd;
        illegal  = 1'b0;
        pc_write = 1'b0;
        branch   = 1'b0;
        unique case (state_q)
            StFetch: begin
                MemRead  = 1'b1;
                IRWrite  = 1'b1;
                ALUSrcB  = SrcBOne;
                ALUSel   = AluAdd;
                PCSource = PcSrcAlu;
                pc_write = 1'b1;
            end
            StDecode: begin
                // ALUOut picks up the branch target while the opcode is decoded.
                ALUSrcB = SrcBImm;
                ALUSel  = AluAdd;
                illegal = ~op_legal;
            end
            StMemAdr, StAddiEx: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
                ALUSel  = AluAdd;
            end
            StMemRd: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            StMemWr: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBReg;
                ALUSel  = func_sel;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            StBranch: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SrcBReg;
                ALUSel   = AluSub;
                PCSource = PcSrcAluOut;
                branch   = 1'b1;
            end
            StJump: begin
                PCSource = PcSrcJump;
                pc_write = 1'b1;
            end
            StAddiWb: begin
                RegWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCEn  = pc_write | (branch & branch_taken);
    assign state = state_q;

endmodule
